// File: rtl/chacha_block_function.sv
`default_nettype none
//==============================================================================
// Module  : chacha_block_function
// Brief   : Iterative ChaCha block function that runs one round per cycle.
//           When CHACHA_FINAL_ADD_EN is defined, the output is work+init (the
//           RFC keystream). Otherwise the output is the raw permutation.
// Rev     : 1.0
//==============================================================================
module chacha_block_function #(
    parameter int DATA_W      = 512,
    parameter int ROUND_COUNT = 20
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              i_tvalid,
    output logic              i_tready,
    input  logic [DATA_W-1:0] i_tdata,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [DATA_W-1:0] o_tdata
);

    localparam int RND_W = $clog2(ROUND_COUNT);
    localparam logic [RND_W-1:0] C_LAST_RND = RND_W'(ROUND_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [RND_W-1:0]  r_rnd;
    logic [DATA_W-1:0] r_work;
`ifdef CHACHA_FINAL_ADD_EN
    logic [DATA_W-1:0] r_init;
`endif

    logic [31:0]       w_x  [16];
    logic [31:0]       w_nx [16];
    logic [DATA_W-1:0] w_round;
    logic [DATA_W-1:0] w_final;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Returns the updated words packed as {a, b, c, d}.
    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_x[k] = r_work[32*k +: 32];
        end
    end

    // Odd rounds use the diagonal pattern, even rounds use the column pattern.
    always_comb begin
        logic [3:0]   w_ia, w_ib, w_ic, w_id;
        logic [127:0] w_q;
        w_nx    = w_x;
        w_round = '0;
        for (int i = 0; i < 4; i++) begin
            w_ia = 4'(i);
            if (r_rnd[0]) begin
                w_ib = 4'(4  + ((i + 1) % 4));
                w_ic = 4'(8  + ((i + 2) % 4));
                w_id = 4'(12 + ((i + 3) % 4));
            end else begin
                w_ib = 4'(4  + i);
                w_ic = 4'(8  + i);
                w_id = 4'(12 + i);
            end
            w_q = qr(w_x[w_ia], w_x[w_ib], w_x[w_ic], w_x[w_id]);
            w_nx[w_ia] = w_q[127:96];
            w_nx[w_ib] = w_q[95:64];
            w_nx[w_ic] = w_q[63:32];
            w_nx[w_id] = w_q[31:0];
        end
        for (int k = 0; k < 16; k++) begin
            w_round[32*k +: 32] = w_nx[k];
        end
    end

`ifdef CHACHA_FINAL_ADD_EN
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_final[32*k +: 32] = r_work[32*k +: 32] + r_init[32*k +: 32];
        end
    end
`else
    assign w_final = r_work;
`endif

    assign i_tready = (r_state == S_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_rnd    <= '0;
            r_work   <= '0;
`ifdef CHACHA_FINAL_ADD_EN
            r_init   <= '0;
`endif
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
        end else if (srst) begin
            r_state  <= S_IDLE;
            r_rnd    <= '0;
            r_work   <= '0;
`ifdef CHACHA_FINAL_ADD_EN
            r_init   <= '0;
`endif
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_tvalid) begin
                        r_work  <= i_tdata;
`ifdef CHACHA_FINAL_ADD_EN
                        r_init  <= i_tdata;
`endif
                        r_rnd   <= '0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_work <= w_round;
                    r_rnd  <= r_rnd + RND_W'(1);
                    if (r_rnd == C_LAST_RND) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    o_tdata  <= w_final;
                    o_tvalid <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (o_tready) begin
                        o_tvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chacha_block_function.sv
`default_nettype none
//==============================================================================
// Module  : tb_chacha_block_function
// Brief   : Directed self-checking bench for chacha_block_function (20 and 8 rounds).
// Rev     : 1.0
//==============================================================================
module tb_chacha_block_function;

    logic         clk = 1'b0;
    logic         aresetn, srst;
    logic         i_tvalid, i_tready, o_tvalid, o_tready;
    logic [511:0] i_tdata, o_tdata;
    logic         i8_tvalid, i8_tready, o8_tvalid, o8_tready;
    logic [511:0] i8_tdata, o8_tdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    localparam logic [511:0] VEC_IN = 512'h00000000_4a000000_09000000_00000001_1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100_6b206574_79622d32_3320646e_61707865;
`ifdef CHACHA_FINAL_ADD_EN
    localparam bit           ADD     = 1'b1;
    localparam logic [511:0] VEC_EXP = 512'h4e3c50a2_e883d0cb_b94e16de_d19c12b5_a2028bd9_05d7c214_09aa9f07_466482d2_4e6cd4c3_9aaa2204_0368c033_c7f4d1c7_c47120a3_1fdd0f50_15593bd1_e4e7f110;
`else
    localparam bit           ADD     = 1'b0;
    localparam logic [511:0] VEC_EXP = 512'h4e3c50a2_9e83d0cb_b04e16de_d19c12b4_82e46ebd_eabda8fc_f29489f3_335271c2_3f5ec7b7_8fa018fc_fc62bb2f_c4f2d0c7_5950bb2f_a67ae21e_e238d763_837778ab;
`endif

    chacha_block_function #(.DATA_W(512), .ROUND_COUNT(20)) dut (
        .aclk(clk), .aresetn(aresetn), .srst(srst),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata)
    );

    chacha_block_function #(.DATA_W(512), .ROUND_COUNT(8)) dut8 (
        .aclk(clk), .aresetn(aresetn), .srst(srst),
        .i_tvalid(i8_tvalid), .i_tready(i8_tready), .i_tdata(i8_tdata),
        .o_tvalid(o8_tvalid), .o_tready(o8_tready), .o_tdata(o8_tdata)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] qrm(input logic [511:0] s, input int a, input int b,
                                         input int c, input int d);
        logic [31:0] xa, xb, xc, xd;
        logic [511:0] r;
        r = s;
        xa = s[32*a +: 32]; xb = s[32*b +: 32]; xc = s[32*c +: 32]; xd = s[32*d +: 32];
        xa = xa + xb; xd = rl(xd ^ xa, 16);
        xc = xc + xd; xb = rl(xb ^ xc, 12);
        xa = xa + xb; xd = rl(xd ^ xa, 8);
        xc = xc + xd; xb = rl(xb ^ xc, 7);
        r[32*a +: 32] = xa; r[32*b +: 32] = xb; r[32*c +: 32] = xc; r[32*d +: 32] = xd;
        return r;
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int rounds, input bit add);
        logic [511:0] x;
        x = s;
        for (int r = 0; r < rounds; r += 2) begin
            x = qrm(x, 0, 4, 8, 12);  x = qrm(x, 1, 5, 9, 13);
            x = qrm(x, 2, 6, 10, 14); x = qrm(x, 3, 7, 11, 15);
            x = qrm(x, 0, 5, 10, 15); x = qrm(x, 1, 6, 11, 12);
            x = qrm(x, 2, 7, 8, 13);  x = qrm(x, 3, 4, 9, 14);
        end
        if (add) begin
            for (int k = 0; k < 16; k++) x[32*k +: 32] = x[32*k +: 32] + s[32*k +: 32];
        end
        return x;
    endfunction

    // Present a block to the 20-round core and return just after the accepting edge.
    task automatic send(input logic [511:0] d);
        int t;
        t = 0;
        i_tdata  = d;
        i_tvalid = 1'b1;
        while (!i_tready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!o_tvalid && cyc < 200);
    endtask

    task automatic test_reset;
        aresetn = 1'b0; srst = 1'b0; o_tready = 1'b1; o8_tready = 1'b1;
        i_tvalid = 1'b0; i_tdata = '0; i8_tvalid = 1'b0; i8_tdata = '0;
        #12;
        n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL reset_itready got %b want 1", i_tready); end
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_otvalid got %b want 0", o_tvalid); end
        n_checks++; if (o_tdata !== '0) begin n_fail++; $display("FAIL reset_otdata got %h want 0", o_tdata); end
        @(negedge clk); aresetn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (i_tready !== 1'b1 || o_tvalid !== 1'b0 || o8_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got itready=%b otvalid=%b o8tvalid=%b want 1 0 0", i_tready, o_tvalid, o8_tvalid);
        end
    endtask

    task automatic test_rfc_vector;
        int cyc;
        o_tready = 1'b1;
        send(VEC_IN);
        wait_valid(cyc);
        n_checks++; if (cyc != 21) begin n_fail++; $display("FAIL rfc_latency got %0d want 21", cyc); end
        n_checks++; if (o_tdata !== VEC_EXP) begin n_fail++; $display("FAIL rfc_data got %h want %h", o_tdata, VEC_EXP); end
        @(posedge clk); #1;
        n_checks++; if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            n_fail++; $display("FAIL rfc_handshake got otvalid=%b itready=%b want 0 1", o_tvalid, i_tready);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        o_tready = 1'b0;
        send(VEC_IN);
        wait_valid(cyc);
        n_checks++; if (cyc != 21) begin n_fail++; $display("FAIL bp_latency got %0d want 21", cyc); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== VEC_EXP || i_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got otvalid=%b itready=%b data=%h want 1 0 %h", i, o_tvalid, i_tready, o_tdata, VEC_EXP);
            end
        end
        o_tready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got otvalid=%b itready=%b want 0 1", o_tvalid, i_tready);
        end
    endtask

    task automatic test_back_to_back;
        int loads, nout;
        int out_cyc [2];
        logic [511:0] out_dat [2];
        logic rdy;
        loads = 0; nout = 0;
        out_cyc[0] = -1; out_cyc[1] = -1; out_dat[0] = '0; out_dat[1] = '0;
        o_tready = 1'b1;
        i_tdata  = VEC_IN;
        i_tvalid = 1'b1;
        for (int c = 0; c < 46; c++) begin
            rdy = i_tready;
            @(posedge clk); #1;
            if (rdy) loads++;
            if (o_tvalid) begin
                if (nout < 2) begin out_cyc[nout] = c; out_dat[nout] = o_tdata; end
                nout++;
            end
        end
        i_tvalid = 1'b0;
        n_checks++; if (loads != 2) begin n_fail++; $display("FAIL b2b_loads got %0d want 2", loads); end
        n_checks++; if (nout != 2) begin n_fail++; $display("FAIL b2b_outputs got %0d want 2", nout); end
        n_checks++; if (out_cyc[0] != 21) begin n_fail++; $display("FAIL b2b_first_cycle got %0d want 21", out_cyc[0]); end
        n_checks++; if (out_cyc[1] - out_cyc[0] != 23) begin n_fail++; $display("FAIL b2b_spacing got %0d want 23", out_cyc[1] - out_cyc[0]); end
        n_checks++; if (out_dat[0] !== VEC_EXP) begin n_fail++; $display("FAIL b2b_data0 got %h want %h", out_dat[0], VEC_EXP); end
        n_checks++; if (out_dat[1] !== VEC_EXP) begin n_fail++; $display("FAIL b2b_data1 got %h want %h", out_dat[1], VEC_EXP); end
    endtask

    task automatic test_reset_mid;
        int cyc, seen;
        logic [511:0] vec2, exp2;
        vec2 = VEC_IN;
        vec2[32*12 +: 32] = 32'h00000002;
        exp2 = chacha_ref(vec2, 20, ADD);
        o_tready = 1'b1;

        send(VEC_IN);
        repeat (4) @(posedge clk);
        #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        n_checks++; if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            n_fail++; $display("FAIL srst_abort got otvalid=%b itready=%b want 0 1", o_tvalid, i_tready);
        end
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (o_tvalid) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL srst_no_output got %0d valid cycles want 0", seen); end
        send(VEC_IN);
        wait_valid(cyc);
        n_checks++; if (cyc != 21 || o_tdata !== VEC_EXP) begin
            n_fail++; $display("FAIL srst_fresh got lat=%0d data=%h want 21 %h", cyc, o_tdata, VEC_EXP);
        end
        @(posedge clk); #1;

        send(VEC_IN);
        repeat (4) @(posedge clk);
        #1 aresetn = 1'b0;
        #1;
        n_checks++; if (o_tvalid !== 1'b0 || i_tready !== 1'b1 || o_tdata !== '0) begin
            n_fail++; $display("FAIL arst_abort got otvalid=%b itready=%b data=%h want 0 1 0", o_tvalid, i_tready, o_tdata);
        end
        @(negedge clk); aresetn = 1'b1;
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (o_tvalid) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL arst_no_output got %0d valid cycles want 0", seen); end
        send(vec2);
        wait_valid(cyc);
        n_checks++; if (cyc != 21 || o_tdata !== exp2) begin
            n_fail++; $display("FAIL arst_fresh got lat=%0d data=%h want 21 %h", cyc, o_tdata, exp2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rounds8;
        int cyc, t;
        logic [511:0] exp8;
        exp8 = chacha_ref(VEC_IN, 8, ADD);
        o8_tready = 1'b1;
        i8_tdata  = VEC_IN;
        i8_tvalid = 1'b1;
        t = 0;
        while (!i8_tready && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        i8_tvalid = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!o8_tvalid && cyc < 200);
        n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL r8_latency got %0d want 9", cyc); end
        n_checks++; if (o8_tdata !== exp8) begin n_fail++; $display("FAIL r8_data got %h want %h", o8_tdata, exp8); end
        @(posedge clk); #1;
        n_checks++; if (o8_tvalid !== 1'b0 || i8_tready !== 1'b1) begin
            n_fail++; $display("FAIL r8_handshake got otvalid=%b itready=%b want 0 1", o8_tvalid, i8_tready);
        end
    endtask

    initial begin
        test_reset();
        test_rfc_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_rounds8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
